// File: rtl/chunk_adder_pkg.sv
// chunk_adder_pkg: shared FSM state enum and default WIDTH/CHUNK constants
package chunk_adder_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/chunk_adder_if.sv
// chunk_adder_if: request (start/sub/carry_in/a/b) and response (ready/done/result/carry_out/overflow/zero) bundle
interface chunk_adder_if import chunk_adder_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic start, sub, carry_in, ready, done, carry_out, overflow, zero;
  logic [WIDTH-1:0] a, b, result;
  modport master(output start, sub, carry_in, a, b, input ready, done, result, carry_out, overflow, zero);
  modport slave(input start, sub, carry_in, a, b, output ready, done, result, carry_out, overflow, zero);
endinterface

// File: rtl/chunk_slice.sv
// chunk_slice: CHUNK-bit ripple adder; ports a, b, ci in; s, co (carry out), cm (carry into MSB) out
module chunk_slice #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);
  logic c;
  always_comb begin
    s = '0;
    c = ci;
    cm = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      cm = c;
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle add/sub, CHUNK bits per clock; ports clock, resetn (sync active-low), bus (chunk_adder_if.slave)
module chunk_adder import chunk_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic clock,
  input logic resetn,
  chunk_adder_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, work, work_n;
  logic [CHUNK-1:0] s_sum;
  logic cy, s_co, s_cm;
  chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a(a_q[idx*CHUNK +: CHUNK]),
    .b(b_q[idx*CHUNK +: CHUNK]),
    .ci(cy),
    .s(s_sum),
    .co(s_co),
    .cm(s_cm)
  );
  always_comb begin
    work_n = work;
    work_n[idx*CHUNK +: CHUNK] = s_sum;
  end
  assign bus.ready = state == IDLE;
  assign bus.done = state == DONE;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      idx <= '0;
      cy <= 1'b0;
      bus.result <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.sub ? ~bus.b : bus.b;
          cy <= bus.sub | bus.carry_in;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          work <= work_n;
          cy <= s_co;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state <= DONE;
            bus.result <= work_n;
            bus.carry_out <= s_co;
            bus.overflow <= s_co ^ s_cm;
            bus.zero <= work_n == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: scoreboard bench for chunk_adder (16/4 instance plus 8/8 single-chunk instance)
module tb_chunk_adder;
  typedef struct packed {logic [15:0] r; logic co, ov, z;} exp_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  int ndone = 0;
  exp_t sb[$];
  exp_t last;
  chunk_adder_if #(.WIDTH(16)) bus0();
  chunk_adder_if #(.WIDTH(8)) bus1();
  chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0(.clock(clock), .resetn(resetn), .bus(bus0));
  chunk_adder #(.WIDTH(8), .CHUNK(8)) dut1(.clock(clock), .resetn(resetn), .bus(bus1));
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [15:0] a, b, input logic sub, ci);
    logic [15:0] bb;
    logic [16:0] t;
    exp_t e;
    bb = sub ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + 17'(sub | ci);
    e.r = t[15:0];
    e.co = t[16];
    e.ov = (a[15] == bb[15]) && (t[15] != a[15]);
    e.z = t[15:0] == 16'h0;
    return e;
  endfunction

  always @(negedge clock) if (bus0.done) begin
    ndone++;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_done result=%h", bus0.result);
    end else begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (bus0.result !== e.r) begin errors++; $display("FAIL result got=%h exp=%h", bus0.result, e.r); end
      if (bus0.carry_out !== e.co) begin errors++; $display("FAIL carry_out got=%b exp=%b", bus0.carry_out, e.co); end
      if (bus0.overflow !== e.ov) begin errors++; $display("FAIL overflow got=%b exp=%b", bus0.overflow, e.ov); end
      if (bus0.zero !== e.z) begin errors++; $display("FAIL zero got=%b exp=%b", bus0.zero, e.z); end
    end
  end

  task automatic start_op(input logic [15:0] a, b, input logic sub, ci, input bit push);
    bus0.a = a; bus0.b = b; bus0.sub = sub; bus0.carry_in = ci; bus0.start = 1'b1;
    if (push) begin last = model(a, b, sub, ci); sb.push_back(last); end
    @(posedge clock); #1;
    bus0.start = 1'b0;
    bus0.a = 16'($urandom); bus0.b = 16'($urandom);
    bus0.sub = 1'($urandom); bus0.carry_in = 1'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus0.done && lat < 20) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic test_reset;
    checks += 6;
    if (bus0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus0.ready); end
    if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
    if (bus0.result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", bus0.result); end
    if (bus0.carry_out !== 1'b0) begin errors++; $display("FAIL reset_co got=%b exp=0", bus0.carry_out); end
    if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", bus0.overflow); end
    if (bus0.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus0.zero); end
  endtask

  task automatic test_op(input string name, input logic [15:0] a, b, input logic sub, ci);
    int lat;
    start_op(a, b, sub, ci, 1);
    wait_done(1, lat);
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL %s_latency got=%0d exp=5", name, lat); end
    if (bus0.ready !== 1'b0) begin errors++; $display("FAIL %s_ready_in_done got=%b exp=0", name, bus0.ready); end
    @(posedge clock); #1;
    checks++;
    if (bus0.ready !== 1'b1 || bus0.done !== 1'b0) begin
      errors++; $display("FAIL %s_back_to_idle ready=%b done=%b exp ready=1 done=0", name, bus0.ready, bus0.done);
    end
  endtask

  task automatic test_start_ignored;
    int lat, n0;
    n0 = ndone;
    start_op(16'h1234, 16'h0FCB, 1'b0, 1'b1, 1);
    bus0.start = 1'b1; bus0.a = 16'h1111; bus0.b = 16'h2222;
    @(posedge clock); #1;
    bus0.start = 1'b0;
    wait_done(2, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (ndone - n0 !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone - n0); end
  endtask

  task automatic test_hold;
    int lat;
    checks++;
    if (bus0.result !== last.r) begin errors++; $display("FAIL hold_idle got=%h exp=%h", bus0.result, last.r); end
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0);
    @(posedge clock); #1;
    checks++;
    if (bus0.result !== last.r) begin errors++; $display("FAIL hold_run got=%h exp=%h", bus0.result, last.r); end
    last = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    sb.push_back(last);
    wait_done(2, lat);
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus0.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus0.ready); end
      start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      wait_done(1, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    start_op(16'h4321, 16'h1111, 1'b0, 1'b0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    test_reset();
    resetn = 1'b1;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
    wait_done(1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL post_reset_latency got=%0d exp=5", lat); end
    @(posedge clock); #1;
  endtask

  task automatic test_single_chunk;
    int lat;
    bus1.a = 8'h80; bus1.b = 8'h80; bus1.sub = 1'b0; bus1.carry_in = 1'b0; bus1.start = 1'b1;
    @(posedge clock); #1;
    bus1.start = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00;
    lat = 1;
    while (!bus1.done && lat < 20) begin @(posedge clock); #1; lat++; end
    checks += 5;
    if (lat !== 2) begin errors++; $display("FAIL n1_latency got=%0d exp=2", lat); end
    if (bus1.result !== 8'h00) begin errors++; $display("FAIL n1_result got=%h exp=00", bus1.result); end
    if (bus1.carry_out !== 1'b1) begin errors++; $display("FAIL n1_co got=%b exp=1", bus1.carry_out); end
    if (bus1.overflow !== 1'b1) begin errors++; $display("FAIL n1_ov got=%b exp=1", bus1.overflow); end
    if (bus1.zero !== 1'b1) begin errors++; $display("FAIL n1_zero got=%b exp=1", bus1.zero); end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.sub = 1'b0; bus0.carry_in = 1'b0; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.carry_in = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    resetn = 1'b1;
    test_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    test_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    test_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0);
    test_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);
    test_start_ignored();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
